// File: rtl/ex_wb_register_pkg.sv
// ---------------------------------------------------------------------------
// ex_wb_register_pkg
// Shared definitions for the execute/writeback pipeline register:
//   - wb_state_t : register occupancy state (EMPTY / FULL / STORE_WAIT)
//   - CLS_*      : one-hot instruction class selects, bit order
//                  {store, branch, writeback} as used by the output router
//   - default widths for the register and its store wait
// ---------------------------------------------------------------------------
package ex_wb_register_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int REG_AW_DEF   = 5;
    localparam int RAM_WAIT_DEF = 1;

    typedef enum logic [1:0] {
        EMPTY      = 2'b00,
        FULL       = 2'b01,
        STORE_WAIT = 2'b10
    } wb_state_t;

    localparam logic [2:0] CLS_STORE  = 3'b100;
    localparam logic [2:0] CLS_BRANCH = 3'b010;
    localparam logic [2:0] CLS_WB     = 3'b001;

    // A class is legal only when exactly one of the three flags is set.
    function automatic logic cls_one_hot(input logic [2:0] cls);
        return (cls == CLS_STORE) || (cls == CLS_BRANCH) || (cls == CLS_WB);
    endfunction

endpackage

// File: rtl/ex_wb_register_store_wait_counter.sv
// ---------------------------------------------------------------------------
// store_wait_counter
// 4-bit down-counter that times how long a store stays in the
// execute/writeback register.
//   clk, rst_n : clock, asynchronous active-low reset (count returns to 0)
//   load       : load load_val (takes priority over dec)
//   load_val   : remaining extra cycles minus one
//   dec        : decrement by one, saturating at zero
//   zero       : count is zero; the store is in its last waiting cycle
// ---------------------------------------------------------------------------
module store_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/ex_wb_register.sv
// ---------------------------------------------------------------------------
// ex_wb_register
// Pipeline register between execute and writeback. Captures the ALU result,
// destination GPR, RAM address and one-hot class every cycle, holds stores
// for RAM_WAIT extra cycles while stalling execute, and inserts bubbles on
// flush, idle input or an illegal (non one-hot) class.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid                : execute stage holds a real instruction
//   in_store/branch/writeback : instruction class (legal when one-hot)
//   in_result, in_dst, in_ramaddr : instruction payload
//   flush                   : branch flush, turns the capture into a bubble
//   ex_stall                : hold execute and earlier stages
//   wb_valid, wb_store/branch/writeback, wb_result, wb_dst, wb_ramaddr
//                           : registered contents (bubble fields are 0)
//   gpr_we, ram_we, pc_load : write/load enables decoded from the contents
//   illegal_op              : sticky, set by an illegal class, reset only
// ---------------------------------------------------------------------------
module ex_wb_register
    import ex_wb_register_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int RAM_WAIT = RAM_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_store,
    input  logic              in_branch,
    input  logic              in_writeback,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_AW-1:0] in_dst,
    input  logic [DATA_W-1:0] in_ramaddr,
    input  logic              flush,
    output logic              ex_stall,
    output logic              wb_valid,
    output logic              wb_store,
    output logic              wb_branch,
    output logic              wb_writeback,
    output logic [DATA_W-1:0] wb_result,
    output logic [REG_AW-1:0] wb_dst,
    output logic [DATA_W-1:0] wb_ramaddr,
    output logic              gpr_we,
    output logic              ram_we,
    output logic              pc_load,
    output logic              illegal_op
);

    localparam logic       HAS_WAIT  = (RAM_WAIT > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(RAM_WAIT - 1) : 4'd0;

    wb_state_t   state;
    wb_state_t   state_nxt;
    logic [2:0]  wb_cls;
    logic [2:0]  in_cls;
    logic        capture_en;
    logic        take;
    logic        bad_cls;
    logic        cnt_load;
    logic        cnt_zero;

    assign in_cls     = {in_store, in_branch, in_writeback};
    // Inputs are only looked at when no store is draining; flush beats in_valid.
    assign capture_en = (state != STORE_WAIT);
    assign take       = capture_en && !flush && in_valid && cls_one_hot(in_cls);
    assign bad_cls    = capture_en && !flush && in_valid && !cls_one_hot(in_cls);
    assign cnt_load   = take && in_store && HAS_WAIT;

    store_wait_counter u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (state == STORE_WAIT),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY, FULL: begin
                if (take) begin
                    state_nxt = (in_store && HAS_WAIT) ? STORE_WAIT : FULL;
                end else begin
                    state_nxt = EMPTY;
                end
            end
            // The store keeps its slot for one more cycle in FULL after the
            // counter expires, giving RAM_WAIT+1 cycles of occupancy.
            STORE_WAIT: begin
                if (cnt_zero) begin
                    state_nxt = FULL;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Register contents: frozen while a store drains, bubble fields are 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_cls     <= 3'b000;
            wb_result  <= '0;
            wb_dst     <= '0;
            wb_ramaddr <= '0;
        end else if (capture_en) begin
            if (take) begin
                wb_valid   <= 1'b1;
                wb_cls     <= in_cls;
                wb_result  <= in_result;
                wb_dst     <= in_dst;
                wb_ramaddr <= in_ramaddr;
            end else begin
                wb_valid   <= 1'b0;
                wb_cls     <= 3'b000;
                wb_result  <= '0;
                wb_dst     <= '0;
                wb_ramaddr <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
        end else if (bad_cls) begin
            illegal_op <= 1'b1;
        end
    end

    // Output decode from registered state only
    always_comb begin
        wb_store     = wb_cls[2];
        wb_branch    = wb_cls[1];
        wb_writeback = wb_cls[0];
        gpr_we       = wb_valid & wb_cls[0];
        ram_we       = wb_valid & wb_cls[2];
        pc_load      = wb_valid & wb_cls[1];
        ex_stall     = (state == STORE_WAIT);
    end

endmodule

// File: tb/tb_ex_wb_register.sv
// ---------------------------------------------------------------------------
// tb_ex_wb_register
// Drives two instances (RAM_WAIT=2 and RAM_WAIT=0) with the same stimulus.
// A reference model tracks each register's contents and remaining store
// occupancy; the expected outputs are queued after every clock edge and a
// monitor pops and compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_ex_wb_register;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 78;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_store = 1'b0;
    logic          in_branch = 1'b0;
    logic          in_writeback = 1'b0;
    logic [DW-1:0] in_result = '0;
    logic [AW-1:0] in_dst = '0;
    logic [DW-1:0] in_ramaddr = '0;
    logic          flush = 1'b0;

    logic          a_stall, a_valid, a_st, a_br, a_wb, a_gwe, a_rwe, a_pcl, a_ill;
    logic [DW-1:0] a_res, a_addr;
    logic [AW-1:0] a_dst;
    logic          b_stall, b_valid, b_st, b_br, b_wb, b_gwe, b_rwe, b_pcl, b_ill;
    logic [DW-1:0] b_res, b_addr;
    logic [AW-1:0] b_dst;

    always #5 clk = ~clk;

    ex_wb_register #(.DATA_W(DW), .REG_AW(AW), .RAM_WAIT(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_store(in_store),
        .in_branch(in_branch), .in_writeback(in_writeback), .in_result(in_result),
        .in_dst(in_dst), .in_ramaddr(in_ramaddr), .flush(flush), .ex_stall(a_stall),
        .wb_valid(a_valid), .wb_store(a_st), .wb_branch(a_br), .wb_writeback(a_wb),
        .wb_result(a_res), .wb_dst(a_dst), .wb_ramaddr(a_addr), .gpr_we(a_gwe),
        .ram_we(a_rwe), .pc_load(a_pcl), .illegal_op(a_ill)
    );

    ex_wb_register #(.DATA_W(DW), .REG_AW(AW), .RAM_WAIT(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_store(in_store),
        .in_branch(in_branch), .in_writeback(in_writeback), .in_result(in_result),
        .in_dst(in_dst), .in_ramaddr(in_ramaddr), .flush(flush), .ex_stall(b_stall),
        .wb_valid(b_valid), .wb_store(b_st), .wb_branch(b_br), .wb_writeback(b_wb),
        .wb_result(b_res), .wb_dst(b_dst), .wb_ramaddr(b_addr), .gpr_we(b_gwe),
        .ram_we(b_rwe), .pc_load(b_pcl), .illegal_op(b_ill)
    );

    logic [OW-1:0] act_a, act_b;
    assign act_a = {a_stall, a_valid, a_st, a_br, a_wb, a_res, a_dst, a_addr,
                    a_gwe, a_rwe, a_pcl, a_ill};
    assign act_b = {b_stall, b_valid, b_st, b_br, b_wb, b_res, b_dst, b_addr,
                    b_gwe, b_rwe, b_pcl, b_ill};

    // Reference model: index 0 mirrors RAM_WAIT=2, index 1 mirrors RAM_WAIT=0
    int            waits [2] = '{2, 0};
    logic          m_valid [2];
    logic [2:0]    m_cls [2];
    logic [DW-1:0] m_res [2];
    logic [AW-1:0] m_dst [2];
    logic [DW-1:0] m_addr [2];
    int            m_rem [2];   // cycles the held store still blocks input
    logic          m_ill [2];

    typedef struct {
        logic [OW-1:0] ea;
        logic [OW-1:0] eb;
        string         tag;
    } exp_t;

    exp_t  q[$];
    string phase = "reset";
    int    errors = 0;
    int    checks = 0;

    task automatic bubble(input int k);
        m_valid[k] = 1'b0;
        m_cls[k]   = 3'b000;
        m_res[k]   = '0;
        m_dst[k]   = '0;
        m_addr[k]  = '0;
    endtask

    task automatic model_reset(input int k);
        bubble(k);
        m_rem[k] = 0;
        m_ill[k] = 1'b0;
    endtask

    task automatic model_step(input int k);
        logic [2:0] c;
        c = {in_store, in_branch, in_writeback};
        if (!rst_n) begin
            model_reset(k);
        end else if (m_rem[k] > 0) begin
            m_rem[k] = m_rem[k] - 1;
        end else if (flush || !in_valid) begin
            bubble(k);
        end else if ($countones(c) != 1) begin
            bubble(k);
            m_ill[k] = 1'b1;
        end else begin
            m_valid[k] = 1'b1;
            m_cls[k]   = c;
            m_res[k]   = in_result;
            m_dst[k]   = in_dst;
            m_addr[k]  = in_ramaddr;
            m_rem[k]   = c[2] ? waits[k] : 0;
        end
    endtask

    function automatic logic [OW-1:0] model_out(input int k);
        logic v;
        logic [2:0] c;
        v = m_valid[k];
        c = m_cls[k];
        return {(m_rem[k] > 0), v, c, m_res[k], m_dst[k], m_addr[k],
                v & c[0], v & c[2], v & c[1], m_ill[k]};
    endfunction

    task automatic push_exp();
        exp_t e;
        e.ea  = model_out(0);
        e.eb  = model_out(1);
        e.tag = phase;
        q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [DW-1:0] r,
                         input logic [AW-1:0] d, input logic [DW-1:0] a, input logic f);
        in_valid = v;
        {in_store, in_branch, in_writeback} = c;
        in_result  = r;
        in_dst     = d;
        in_ramaddr = a;
        flush      = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) model_step(k);
        push_exp();
    endtask

    // Asserted just after a rising edge so the asynchronous path is exercised.
    task automatic mid_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) model_reset(k);
        q.delete();
        phase = "reset_hold";
        push_exp();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic cmp(input string name, input int dut, input logic [OW-1:0] a,
                       input logic [OW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s ram_wait=%0d: got %h expected %h", name, dut, a, e);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            if (clk) begin
                #1;
                cmp("async_reset", 2, act_a, '0);
                cmp("async_reset", 0, act_b, '0);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.tag, 2, act_a, e.ea);
                cmp(e.tag, 0, act_b, e.eb);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] c;
        int         r;
        for (int k = 0; k < 2; k++) model_reset(k);
        drive(1'b0, 3'b000, '0, '0, '0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        phase = "idle";
        step();

        phase = "writeback";
        drive(1'b1, 3'b001, 32'hDEADBEEF, 5'd7, 32'h0, 1'b0);
        step();
        drive(1'b1, 3'b001, 32'h12345678, 5'd9, 32'h0, 1'b0);
        step();

        phase = "store";
        drive(1'b1, 3'b100, 32'h0000_1111, 5'd3, 32'h40, 1'b0);
        step();
        drive(1'b1, 3'b001, 32'h0000_2222, 5'd11, 32'h0, 1'b1);
        step();
        drive(1'b1, 3'b001, 32'h0000_2222, 5'd11, 32'h0, 1'b0);
        step();
        step();
        step();

        phase = "flush";
        drive(1'b1, 3'b001, 32'h0000_3333, 5'd12, 32'h0, 1'b1);
        step();
        phase = "branch";
        drive(1'b1, 3'b010, 32'h100, 5'd0, 32'h0, 1'b0);
        step();

        phase = "illegal";
        drive(1'b1, 3'b011, 32'h5555, 5'd4, 32'h8, 1'b0);
        step();
        drive(1'b1, 3'b001, 32'h6666, 5'd5, 32'h0, 1'b0);
        step();
        drive(1'b1, 3'b000, 32'h7777, 5'd6, 32'h0, 1'b0);
        step();
        drive(1'b1, 3'b010, 32'h200, 5'd1, 32'h0, 1'b0);
        step();

        mid_reset();
        phase = "after_reset";
        drive(1'b1, 3'b001, 32'hCAFE0001, 5'd2, 32'h0, 1'b0);
        step();

        // Store in flight when reset hits
        phase = "store_reset";
        drive(1'b1, 3'b100, 32'h0, 5'd0, 32'h80, 1'b0);
        step();
        drive(1'b0, 3'b000, '0, '0, '0, 1'b0);
        mid_reset();
        phase = "after_reset";
        step();

        for (int i = 0; i < 400; i++) begin
            phase = "random";
            r = $urandom_range(0, 15);
            if (r == 0)      c = 3'($urandom_range(0, 7));
            else if (r < 6)  c = 3'b100;
            else if (r < 10) c = 3'b010;
            else             c = 3'b001;
            drive(($urandom_range(0, 3) != 0), c, $urandom, 5'($urandom),
                  $urandom, ($urandom_range(0, 7) == 0));
            step();
            if (i == 150 || i == 300) mid_reset();
        end

        drive(1'b0, 3'b000, '0, '0, '0, 1'b0);
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
